systolic_feeder: RTL

Input-side driver for the N×N systolic matrix-multiply array. Holds operand matrices A and B in local register buffers loaded over a simple write port. On `start` it streams them into the array's left (A) and top (B) edges with the diagonal skew the PE grid requires. It raises a one-cycle `done` when the stream completes.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_feeder_if.sv | 35 +++
 rtl/matrix_buf.sv | 63 ++++++
 rtl/systolic_feeder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array input feeder.
//   DEF_N / DEF_DW : default array dimension and operand width
//   state_t        : feeder FSM state encoding
//   calc_aw()      : write-address width ({row, col}) for a given N
// Optional feature macro: SYSTOLIC_FEEDER_FLUSH_EN adds the FLUSH state.
package systolic_pkg;

   localparam int DEF_N  = 4;
   localparam int DEF_DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
      ST_FLUSH  = 2'd2,
`endif
      ST_DONE   = 2'd3
   } state_t;

   function automatic int calc_aw(input int n);
      return 2 * $clog2(n);
   endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Bus bundle between a host and the systolic feeder.
//   wr_en/wr_sel/wr_addr/wr_data : operand buffer write port
//   start                        : stream request
//   busy/done                    : stream status
//   a_out/a_valid, b_out/b_valid : skewed left-edge and top-edge lanes
// master = host side, slave = feeder side.
interface systolic_feeder_if
   import systolic_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int DW = DEF_DW,
   parameter int AW = calc_aw(N)
);
   logic            wr_en;
   logic            wr_sel;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic            start;
   logic            busy;
   logic            done;
   logic [N*DW-1:0] a_out;
   logic [N*DW-1:0] b_out;
   logic [N-1:0]    a_valid;
   logic [N-1:0]    b_valid;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start,
      input  busy, done, a_out, b_out, a_valid, b_valid
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start,
      output busy, done, a_out, b_out, a_valid, b_valid
   );
endinterface

// File: rtl/matrix_buf.sv
// N x N x DW operand register file with one diagonal read.
//   clk, rst      : clock, synchronous active-high clear of all elements
//   wr_en_i       : write strobe, wr_addr_i = {row, col}, wr_data_i = value
//   step_i        : diagonal index t
//   lane_data_o   : lane k carries element (k, t-k) when ROW_LANES=1,
//                   element (t-k, k) when ROW_LANES=0; 0 when out of range
//   lane_valid_o  : lane k holds an in-range element
module matrix_buf
   import systolic_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int DW        = DEF_DW,
   parameter bit ROW_LANES = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en_i,
   input  logic [calc_aw(N)-1:0]     wr_addr_i,
   input  logic [DW-1:0]             wr_data_i,
   input  logic [$clog2(2*N)-1:0]    step_i,
   output logic [N*DW-1:0]           lane_data_o,
   output logic [N-1:0]              lane_valid_o
);
   localparam int IW = $clog2(N);
   localparam int AW = calc_aw(N);
   localparam int SW = $clog2(2*N);

   logic [DW-1:0] mem_q [N][N];
   logic [IW-1:0] wr_row;
   logic [IW-1:0] wr_col;

   assign wr_row = wr_addr_i[AW-1 -: IW];
   assign wr_col = wr_addr_i[IW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               mem_q[r][c] <= '0;
            end
         end
      end else if (wr_en_i) begin
         mem_q[wr_row][wr_col] <= wr_data_i;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      localparam logic [SW-1:0] K = SW'(k);
      logic [SW-1:0] off;
      logic          in_rng;
      logic [IW-1:0] idx;

      // off wraps when step_i < k; the explicit >= compare rejects that case
      assign off    = step_i - K;
      assign in_rng = (step_i >= K) && (off < SW'(N));
      assign idx    = off[IW-1:0];

      assign lane_valid_o[k] = in_rng;
      assign lane_data_o[k*DW +: DW] = !in_rng  ? '0 :
                                       ROW_LANES ? mem_q[k][idx] : mem_q[idx][k];
   end

endmodule

// File: rtl/systolic_feeder.sv
// Input-side driver for an N x N systolic matrix-multiply array.
// Buffers A and B, then streams them with diagonal skew: at step t lane i
// of a_out carries A[i][t-i] and lane j of b_out carries B[t-j][j].
//   clk, rst : clock, synchronous active-high reset
//   bus      : systolic_feeder_if.slave (write port, start, busy/done, lanes)
// Optional macro SYSTOLIC_FEEDER_FLUSH_EN: N zero cycles after the stream
// so partial sums drain before done.
//
// state  | meaning
// IDLE   | buffers writable, waiting for start
// STREAM | presenting diagonal t = 0..2N-2
// FLUSH  | N cycles of zero lanes, busy held (macro only)
// DONE   | stream over; done/busy-low appear on the following cycle
//
// All outputs are registered from the current state, so they lag the state
// register by one cycle: the done pulse shows while the FSM already sits in
// IDLE, which lets a start held during the done cycle begin the next stream.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int DW = DEF_DW
) (
   input  logic             clk,
   input  logic             rst,
   systolic_feeder_if.slave bus
);
   localparam int SW = $clog2(2*N);
   localparam logic [SW-1:0] T_LAST = SW'(2*N-2);
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
   localparam logic [SW-1:0] T_FLUSH_LAST = SW'(N-1);
`endif

   state_t          state_q, state_d;
   logic [SW-1:0]   t_q, t_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [N*DW-1:0] a_q, a_d, b_q, b_d;
   logic [N-1:0]    av_q, av_d, bv_q, bv_d;

   logic            buf_we;
   logic [N*DW-1:0] a_diag, b_diag;
   logic [N-1:0]    a_dv, b_dv;

   assign buf_we = bus.wr_en && (state_q == ST_IDLE);

   matrix_buf #(.N(N), .DW(DW), .ROW_LANES(1'b1)) u_buf_a (
      .clk          (clk),
      .rst          (rst),
      .wr_en_i      (buf_we && !bus.wr_sel),
      .wr_addr_i    (bus.wr_addr),
      .wr_data_i    (bus.wr_data),
      .step_i       (t_q),
      .lane_data_o  (a_diag),
      .lane_valid_o (a_dv)
   );

   matrix_buf #(.N(N), .DW(DW), .ROW_LANES(1'b0)) u_buf_b (
      .clk          (clk),
      .rst          (rst),
      .wr_en_i      (buf_we && bus.wr_sel),
      .wr_addr_i    (bus.wr_addr),
      .wr_data_i    (bus.wr_data),
      .step_i       (t_q),
      .lane_data_o  (b_diag),
      .lane_valid_o (b_dv)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         t_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         av_q    <= '0;
         bv_q    <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         a_q     <= a_d;
         b_q     <= b_d;
         av_q    <= av_d;
         bv_q    <= bv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      a_d     = '0;
      b_d     = '0;
      av_d    = '0;
      bv_d    = '0;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               state_d = ST_STREAM;
               t_d     = '0;
               busy_d  = 1'b1;
            end
         end
         ST_STREAM: begin
            busy_d = 1'b1;
            a_d    = a_diag;
            b_d    = b_diag;
            av_d   = a_dv;
            bv_d   = b_dv;
            if (t_q == T_LAST) begin
               t_d = '0;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
               state_d = ST_FLUSH;
`else
               state_d = ST_DONE;
`endif
            end else begin
               t_d = t_q + SW'(1);
            end
         end
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
         ST_FLUSH: begin
            busy_d = 1'b1;
            if (t_q == T_FLUSH_LAST) begin
               t_d     = '0;
               state_d = ST_DONE;
            end else begin
               t_d = t_q + SW'(1);
            end
         end
`endif
         ST_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            t_d     = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.a_out   = a_q;
   assign bus.b_out   = b_q;
   assign bus.a_valid = av_q;
   assign bus.b_valid = bv_q;

endmodule
